alu_rf: RTL and testbench

ALU_RF -- requirements
Module: alu_rf

---
 rtl/alu_rf.sv | 158 +++++++++++++++
 tb/tb_alu_rf.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rf.sv
// alu_rf: register file + ALU with an iterative shift-add multiplier.
// Ports: clk/rst, start/op/a_addr/b_addr/d_addr/b_sel/const_val/we command, rd_addr/rd_data debug read, y/cout/ovf/zero/neg/busy/done status.
module alu_rf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [$clog2(DEPTH)-1:0] a_addr,
  input  logic [$clog2(DEPTH)-1:0] b_addr,
  input  logic [$clog2(DEPTH)-1:0] d_addr,
  input  logic                     b_sel,
  input  logic [WIDTH-1:0]         const_val,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic [WIDTH-1:0]         y,
  output logic                     cout,
  output logic                     ovf,
  output logic                     zero,
  output logic                     neg,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_PAS = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [WIDTH-1:0] rf [DEPTH];
  logic             c_reg;

  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] b_val;
  logic [WIDTH-1:0] b_op;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cout;
  logic             alu_ovf;
  logic             alu_arith;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_nxt;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    m_d;
  logic             m_we;

  assign rd_data = rf[rd_addr];
  assign a_val   = rf[a_addr];
  assign b_val   = b_sel ? const_val : rf[b_addr];

  // SUB reuses the adder as A + ~B + 1
  always_comb begin
    b_op = (op == OP_SUB) ? ~b_val : b_val;
    cin  = 1'b0;
    if (op == OP_SUB) cin = 1'b1;
    if (op == OP_ADC) cin = c_reg;
    sum = {1'b0, a_val} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
  end

  always_comb begin
    alu_y     = '0;
    alu_cout  = 1'b0;
    alu_ovf   = 1'b0;
    alu_arith = 1'b0;
    unique case (op)
      OP_ADD, OP_ADC, OP_SUB: begin
        alu_y     = sum[WIDTH-1:0];
        alu_cout  = sum[WIDTH];
        alu_ovf   = (a_val[WIDTH-1] == b_op[WIDTH-1]) &&
                    (sum[WIDTH-1] != a_val[WIDTH-1]);
        alu_arith = 1'b1;
      end
      OP_AND: alu_y = a_val & b_val;
      OP_OR:  alu_y = a_val | b_val;
      OP_XOR: alu_y = a_val ^ b_val;
      OP_PAS: alu_y = b_val;
      OP_MUL: alu_y = '0;
      default: alu_y = '0;
    endcase
  end

  assign acc_nxt = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      y      <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      c_reg  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      m_d    <= '0;
      m_we   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        acc    <= acc_nxt;
        mcand  <= {mcand[PW-2:0], 1'b0};
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        // last partial product folds straight into the result
        if (cnt == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
          y    <= acc_nxt[WIDTH-1:0];
          cout <= |acc_nxt[PW-1:WIDTH];
          ovf  <= 1'b0;
          zero <= ~|acc_nxt[WIDTH-1:0];
          neg  <= acc_nxt[WIDTH-1];
          if (m_we) rf[m_d] <= acc_nxt[WIDTH-1:0];
        end
      end else if (start) begin
        if (op == OP_MUL) begin
          busy   <= 1'b1;
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, a_val};
          mplier <= b_val;
          cnt    <= '0;
          m_d    <= d_addr;
          m_we   <= we;
        end else begin
          done <= 1'b1;
          y    <= alu_y;
          cout <= alu_cout;
          ovf  <= alu_ovf;
          zero <= ~|alu_y;
          neg  <= alu_y[WIDTH-1];
          if (alu_arith) c_reg <= alu_cout;
          if (we) rf[d_addr] <= alu_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rf.sv
// tb_alu_rf: random + directed stimulus for alu_rf checked against a behavioural model.
// Ports: none (top-level bench).
module tb_alu_rf;
  localparam int W = 8;
  localparam int D = 8;
  localparam int AW = 3;
  localparam longint FULL = 64'd1 << W;
  localparam longint HALF = 64'd1 << (W - 1);
  localparam longint MASK = FULL - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, b_sel, we;
  logic [2:0]    op;
  logic [AW-1:0] a_addr, b_addr, d_addr, rd_addr;
  logic [W-1:0]  const_val, rd_data, y;
  logic          cout, ovf, zero, neg, busy, done;

  alu_rf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a_addr(a_addr), .b_addr(b_addr), .d_addr(d_addr),
    .b_sel(b_sel), .const_val(const_val), .we(we),
    .rd_addr(rd_addr), .rd_data(rd_data), .y(y),
    .cout(cout), .ovf(ovf), .zero(zero), .neg(neg),
    .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model
  longint m_rf [D];
  longint m_y, p_y;
  bit     m_cout, m_ovf, m_zero, m_neg, m_c, m_busy, m_done;
  bit     p_cout, p_we;
  int     m_left, p_d;

  always @(posedge clk) begin : model
    longint a, b, sa, sb, t, ry, prod;
    bit ap, rc, rv, rwc, rwe;
    int rd;
    ap = 0; ry = 0; rc = 0; rv = 0; rwc = 0; rwe = 0; rd = 0;
    t = 0; prod = 0;
    if (rst) begin
      for (int i = 0; i < D; i++) m_rf[i] <= 0;
      m_y <= 0; m_cout <= 0; m_ovf <= 0; m_zero <= 0; m_neg <= 0;
      m_c <= 0; m_busy <= 0; m_done <= 0; m_left <= 0;
    end else begin
      m_done <= 0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          ap = 1; ry = p_y; rc = p_cout; rwe = p_we; rd = p_d;
          m_busy <= 0;
        end
      end else if (start) begin
        a  = m_rf[a_addr];
        b  = b_sel ? longint'(const_val) : m_rf[b_addr];
        sa = (a >= HALF) ? a - FULL : a;
        sb = (b >= HALF) ? b - FULL : b;
        case (op)
          3'd0: begin ry = (a + b) & MASK; rc = (a + b) >= FULL;
                  t = sa + sb; rwc = 1; end
          3'd1: begin ry = (a + b + m_c) & MASK; rc = (a + b + m_c) >= FULL;
                  t = sa + sb + m_c; rwc = 1; end
          3'd2: begin ry = (a - b + FULL) & MASK; rc = (a >= b);
                  t = sa - sb; rwc = 1; end
          3'd3: ry = a & b;
          3'd4: ry = a | b;
          3'd5: ry = a ^ b;
          3'd6: ry = b;
          default: begin
            prod = a * b;
            p_y <= prod & MASK;
            p_cout <= (prod >> W) != 0;
            p_we <= we;
            p_d <= int'(d_addr);
            m_busy <= 1;
            m_left <= W;
          end
        endcase
        rv = rwc && (t < -HALF || t >= HALF);
        if (op != 3'd7) begin
          ap = 1; rwe = we; rd = int'(d_addr);
        end
      end
      if (ap) begin
        m_y <= ry; m_cout <= rc; m_ovf <= rv;
        m_zero <= (ry == 0); m_neg <= ry[W-1];
        if (rwc) m_c <= rc;
        if (rwe) m_rf[rd] <= ry;
        m_done <= 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("y", y, m_y);
      check("cout", cout, m_cout);
      check("ovf", ovf, m_ovf);
      check("zero", zero, m_zero);
      check("neg", neg, m_neg);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("rd_data", rd_data, m_rf[rd_addr]);
    end
  end

  task automatic scramble();
    op = 3'($urandom); a_addr = AW'($urandom); b_addr = AW'($urandom);
    d_addr = AW'($urandom); b_sel = 1'($urandom);
    const_val = W'($urandom); we = 1'($urandom); rd_addr = AW'($urandom);
  endtask

  // issue one command, then wait for done; poke re-raises start mid-command
  task automatic cmd(input logic [2:0] o, input int a, input int b,
                     input int d, input bit bs, input int k, input bit w,
                     input int poke, output int lat, output int nb);
    bit seen;
    @(negedge clk); #1;
    start = 1; op = o; a_addr = AW'(a); b_addr = AW'(b); d_addr = AW'(d);
    b_sel = bs; const_val = W'(k); we = w;
    nb = 0; seen = 0; lat = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) nb++;
      seen = done;
      #1;
      start = (lat == poke);
      scramble();
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic peek(string n, int addr, logic [63:0] exp);
    rd_addr = AW'(addr); #1;
    check(n, rd_data, exp);
  endtask

  int lat, nb;
  bit saw;

  initial begin
    rst = 1; start = 0; op = 0; a_addr = 0; b_addr = 0; d_addr = 0;
    b_sel = 0; const_val = 0; we = 0; rd_addr = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("rst_y", y, 0);
    check("rst_zero", zero, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #1 rst = 0;
    peek("rst_r3", 3, 0);

    cmd(3'd6, 0, 0, 1, 1, 8'h01, 1, 0, lat, nb);
    check("pass_y", y, 8'h01);
    check("pass_lat", lat, 1);
    peek("pass_r1", 1, 8'h01);

    for (int i = 0; i < 13; i++) begin
      cmd(3'd0, 0, 1, i % 2, 0, 0, 1, 0, lat, nb);
      if (i == 11) check("fib_233", y, 8'hE9);
    end
    check("fib_wrap_y", y, 8'h79);
    check("fib_wrap_cout", cout, 1);

    cmd(3'd6, 0, 0, 2, 1, 8'h05, 1, 0, lat, nb);
    cmd(3'd6, 0, 0, 3, 1, 8'h07, 1, 0, lat, nb);
    cmd(3'd2, 2, 3, 4, 0, 0, 1, 0, lat, nb);
    check("sub_y", y, 8'hFE);
    check("sub_cout", cout, 0);
    check("sub_neg", neg, 1);
    cmd(3'd6, 0, 0, 2, 1, 8'h7F, 1, 0, lat, nb);
    cmd(3'd0, 2, 0, 4, 1, 8'h01, 1, 0, lat, nb);
    check("ovf_y", y, 8'h80);
    check("ovf_ovf", ovf, 1);
    check("ovf_neg", neg, 1);
    cmd(3'd6, 0, 0, 2, 1, 8'hFF, 1, 0, lat, nb);
    cmd(3'd0, 2, 0, 4, 1, 8'h01, 1, 0, lat, nb);
    check("wrap_y", y, 8'h00);
    check("wrap_zero", zero, 1);
    check("wrap_cout", cout, 1);
    cmd(3'd6, 0, 0, 2, 1, 8'h00, 1, 0, lat, nb);
    cmd(3'd1, 2, 0, 4, 1, 8'h00, 0, 0, lat, nb);
    check("adc_y", y, 8'h01);

    cmd(3'd6, 0, 0, 2, 1, 8'h0F, 1, 0, lat, nb);
    cmd(3'd7, 2, 0, 5, 1, 8'h13, 1, 3, lat, nb);
    check("mul_y", y, 8'h1D);
    check("mul_cout", cout, 1);
    check("mul_ovf", ovf, 0);
    check("mul_lat", lat, W + 1);
    check("mul_busy_cycles", nb, W);
    peek("mul_r5", 5, 8'h1D);
    @(negedge clk);
    check("mul_done_once", done, 0);
    check("mul_no_queue", busy, 0);

    @(negedge clk); #1;
    start = 1; op = 3'd7; a_addr = 5; b_sel = 1; const_val = 3;
    d_addr = 6; we = 1;
    saw = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (done) saw = 1;
      if (i == 5) check("rstmul_busy", busy, 0);
      #1;
      start = 0;
      rst = (i == 4);
    end
    check("rstmul_no_done", saw, 0);
    check("rstmul_y", y, 0);
    for (int r = 0; r < D; r++) peek("rstmul_reg", r, 0);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      rst = ($urandom_range(0, 79) == 0);
      start = 1'($urandom);
      scramble();
    end
    @(negedge clk); #1;
    rst = 0; start = 0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
